// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Supervises the lock flags of NUM_PLL on-chip PLLs and sequences the resets
// of the clock domains they feed. Every domain reset is held until all locks
// have been stable for LOCK_HOLD_CYCLES. The resets are then released one
// domain at a time, index 0 first, STAGGER_CYCLES apart. Any lock loss
// re-asserts every domain reset. If lock never arrives, the PLLs are
// re-kicked through pll_stdy_rst up to MAX_RETRY times before a sticky fault
// is latched. Runs entirely on the board reference clock.
//
// Ports:
//   clk            reference clock, the only clock of the block
//   rst            synchronous, active-high reset
//   pll_locked     raw PLL lock flags (asynchronous to clk)
//   domain_rst     per-domain reset request, active-high; bit i serves PLL i
//   pll_stdy_rst   steady-lock reset pulse to every PLL
//   all_ready      high while every domain is released (RUN)
//   timeout_err    sticky fault flag, cleared only by rst
//   retry_count    relock attempts since reset, saturating
//
// Optional build macro PLL_SEQ_LOSS_COUNT_EN adds:
//   lock_loss_cnt  saturating count of lock losses seen in RELEASE/RUN
//   last_loss_mask PLLs that were unlocked at the most recent such loss
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned NUM_PLL             = 4,
  parameter int unsigned LOCK_SYNC_STAGES    = 2,
  parameter int unsigned LOCK_HOLD_CYCLES    = 1024,
  parameter int unsigned STAGGER_CYCLES      = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned RELOCK_PULSE_CYCLES = 4,
  parameter int unsigned MAX_RETRY           = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_PLL-1:0] pll_locked,
  output logic [NUM_PLL-1:0] domain_rst,
  output logic               pll_stdy_rst,
  output logic               all_ready,
  output logic               timeout_err,
  output logic [3:0]         retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0]         lock_loss_cnt,
  output logic [NUM_PLL-1:0] last_loss_mask
`endif
);

  // One shared timer serves every state, so it is sized for the longest
  // interval. Each compare fires at N-1, so clog2(N) bits never wrap.
  localparam int unsigned MAX_HS  = (LOCK_HOLD_CYCLES > STAGGER_CYCLES) ?
                                    LOCK_HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned MAX_TP  = (LOCK_TIMEOUT_CYCLES > RELOCK_PULSE_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : RELOCK_PULSE_CYCLES;
  localparam int unsigned TMR_MAX = (MAX_HS > MAX_TP) ? MAX_HS : MAX_TP;
  localparam int unsigned TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned IW      = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;

  localparam logic [TW-1:0] HOLD_LAST    = TW'(LOCK_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(RELOCK_PULSE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_PLL - 1);
  localparam logic [3:0]    RETRY_LIMIT  = (MAX_RETRY > 15) ? 4'd15 : 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_RELOCK,
    S_FAULT
  } state_e;

  // -------------------------------------------------------------------------
  // Lock synchroniser: LOCK_SYNC_STAGES flops per bit; stage 0 is the only
  // one that sees the asynchronous input.
  // -------------------------------------------------------------------------
  logic [NUM_PLL-1:0] sync_q [LOCK_SYNC_STAGES];
  logic [NUM_PLL-1:0] locked_s;
  logic               all_lk;

  // NOTE: sequential state is always updated with <= so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift work.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LOCK_SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pll_locked;
      for (int s = 1; s < LOCK_SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign locked_s = sync_q[LOCK_SYNC_STAGES-1];
  assign all_lk   = &locked_s;

  // -------------------------------------------------------------------------
  // Sequencer state and registered outputs
  // -------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic [TW-1:0]      timer_q,       timer_d;
  logic [IW-1:0]      idx_q,         idx_d;
  logic [NUM_PLL-1:0] domain_rst_q,  domain_rst_d;
  logic               stdy_rst_q,    stdy_rst_d;
  logic               all_ready_q,   all_ready_d;
  logic               timeout_err_q, timeout_err_d;
  logic [3:0]         retry_q,       retry_d;
  logic               loss_evt;

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0]         loss_cnt_q,    loss_cnt_d;
  logic [NUM_PLL-1:0] loss_mask_q,   loss_mask_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    timer_d       = timer_q;
    idx_d         = idx_q;
    domain_rst_d  = domain_rst_q;
    stdy_rst_d    = 1'b0;
    all_ready_d   = all_ready_q;
    timeout_err_d = timeout_err_q;
    retry_d       = retry_q;
    loss_evt      = 1'b0;

    unique case (state_q)
      S_WAIT_LOCK: begin
        timer_d      = timer_q + TW'(1);
        domain_rst_d = '1;
        all_ready_d  = 1'b0;
        // A lock arriving on the timeout cycle wins over the timeout.
        if (all_lk) begin
          state_d = S_HOLD;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_LIMIT) begin
            state_d    = S_RELOCK;
            retry_d    = retry_q + 4'd1;
            stdy_rst_d = 1'b1;
          end else begin
            state_d       = S_FAULT;
            timeout_err_d = 1'b1;
          end
        end
      end

      S_HOLD: begin
        timer_d = timer_q + TW'(1);
        if (!all_lk) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          state_d = S_RELEASE;
          timer_d = '0;
          idx_d   = '0;
        end
      end

      S_RELEASE: begin
        if (!all_lk) begin
          loss_evt = 1'b1;
        end else if (timer_q == STAGGER_LAST) begin
          domain_rst_d[idx_q] = 1'b0;
          idx_d               = idx_q + IW'(1);
          timer_d             = '0;
          if (idx_q == IDX_LAST) begin
            state_d     = S_RUN;
            all_ready_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_RUN: begin
        if (!all_lk) loss_evt = 1'b1;
      end

      S_RELOCK: begin
        // Lock flags are deliberately ignored while the PLLs are being kicked.
        timer_d    = timer_q + TW'(1);
        stdy_rst_d = 1'b1;
        if (timer_q == PULSE_LAST) begin
          state_d    = S_WAIT_LOCK;
          timer_d    = '0;
          stdy_rst_d = 1'b0;
        end
      end

      S_FAULT: begin
        timeout_err_d = 1'b1;
        domain_rst_d  = '1;
        all_ready_d   = 1'b0;
      end

      default: begin
        state_d      = S_WAIT_LOCK;
        timer_d      = '0;
        idx_d        = '0;
        domain_rst_d = '1;
        all_ready_d  = 1'b0;
      end
    endcase

    // Lock loss after release began: slam every domain back into reset.
    if (loss_evt) begin
      state_d      = S_WAIT_LOCK;
      timer_d      = '0;
      idx_d        = '0;
      domain_rst_d = '1;
      all_ready_d  = 1'b0;
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  always_comb begin
    loss_cnt_d  = loss_cnt_q;
    loss_mask_d = loss_mask_q;
    if (loss_evt) begin
      if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
      loss_mask_d = ~locked_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q  <= '0;
      loss_mask_q <= '0;
    end else begin
      loss_cnt_q  <= loss_cnt_d;
      loss_mask_q <= loss_mask_d;
    end
  end

  assign lock_loss_cnt  = loss_cnt_q;
  assign last_loss_mask = loss_mask_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_WAIT_LOCK;
      timer_q       <= '0;
      idx_q         <= '0;
      domain_rst_q  <= '1;
      stdy_rst_q    <= 1'b0;
      all_ready_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      retry_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      domain_rst_q  <= domain_rst_d;
      stdy_rst_q    <= stdy_rst_d;
      all_ready_q   <= all_ready_d;
      timeout_err_q <= timeout_err_d;
      retry_q       <= retry_d;
    end
  end

  assign domain_rst   = domain_rst_q;
  assign pll_stdy_rst = stdy_rst_q;
  assign all_ready    = all_ready_q;
  assign timeout_err  = timeout_err_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer with NUM_PLL=4, SYNC=2, HOLD=8,
// STAGGER=4, TIMEOUT=32, PULSE=2, MAX_RETRY=3. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point, so "edge k"
// is the k-th rising edge that samples the value set before it.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pll_locked;
  logic [3:0] domain_rst;
  logic       pll_stdy_rst;
  logic       all_ready;
  logic       timeout_err;
  logic [3:0] retry_count;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;
  logic [3:0] last_loss_mask;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_PLL            (4),
    .LOCK_SYNC_STAGES   (2),
    .LOCK_HOLD_CYCLES   (8),
    .STAGGER_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .RELOCK_PULSE_CYCLES(2),
    .MAX_RETRY          (3)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .domain_rst    (domain_rst),
    .pll_stdy_rst  (pll_stdy_rst),
    .all_ready     (all_ready),
    .timeout_err   (timeout_err),
    .retry_count   (retry_count)
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .last_loss_mask(last_loss_mask)
`endif
  );

  // Expected domain_rst k edges after locks are first sampled high:
  // bit i drops at edge 14 + 4*i (2 sync + 8 hold + 4 per stagger step).
  function automatic logic [3:0] exp_dr(int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (k < 14 + 4 * i) ? 1'b1 : 1'b0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 4'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (domain_rst !== 4'hF) begin
      failures++;
      $display("FAIL reset_domain_rst got=%h exp=%h", domain_rst, 4'hF);
    end
    checks++;
    if (pll_stdy_rst !== 1'b0) begin
      failures++;
      $display("FAIL reset_stdy_rst got=%b exp=0", pll_stdy_rst);
    end
    checks++;
    if (all_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_all_ready got=%b exp=0", all_ready);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout_err got=%b exp=0", timeout_err);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_retry_count got=%0d exp=0", retry_count);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0 || last_loss_mask !== 4'h0) begin
      failures++;
      $display("FAIL reset_loss_regs got=%0d/%h exp=0/0", lock_loss_cnt, last_loss_mask);
    end
`endif
  endtask

  task automatic test_clean_bringup();
    do_reset();
    pll_locked = 4'hF;
    for (int k = 0; k <= 27; k++) begin
      step();
      checks++;
      if (domain_rst !== exp_dr(k)) begin
        failures++;
        $display("FAIL bringup_dr edge=%0d got=%h exp=%h", k, domain_rst, exp_dr(k));
      end
      checks++;
      if (all_ready !== (k >= 26)) begin
        failures++;
        $display("FAIL bringup_ready edge=%0d got=%b exp=%b", k, all_ready, (k >= 26));
      end
      checks++;
      if (pll_stdy_rst !== 1'b0) begin
        failures++;
        $display("FAIL bringup_stdy edge=%0d got=%b exp=0", k, pll_stdy_rst);
      end
    end
  endtask

  task automatic test_glitch_hold();
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      pll_locked = (k == 6) ? 4'hB : 4'hF;
      step();
      // Lock is re-sampled high at edge 7, so the pattern restarts there.
      checks++;
      if (domain_rst !== exp_dr(k - 7)) begin
        failures++;
        $display("FAIL glitch_dr edge=%0d got=%h exp=%h", k, domain_rst, exp_dr(k - 7));
      end
      checks++;
      if (all_ready !== 1'b0) begin
        failures++;
        $display("FAIL glitch_ready edge=%0d got=%b exp=0", k, all_ready);
      end
    end
  endtask

  task automatic test_run_loss();
    do_reset();
    pll_locked = 4'hF;
    for (int k = 0; k <= 26; k++) step();
    checks++;
    if (all_ready !== 1'b1 || domain_rst !== 4'h0) begin
      failures++;
      $display("FAIL run_reached got=%b/%h exp=1/0", all_ready, domain_rst);
    end
    pll_locked = 4'hD;
    step();
    step();
    checks++;
    if (domain_rst !== 4'h0 || all_ready !== 1'b1) begin
      failures++;
      $display("FAIL run_loss_early got=%h/%b exp=0/1", domain_rst, all_ready);
    end
    step();
    checks++;
    if (domain_rst !== 4'hF) begin
      failures++;
      $display("FAIL run_loss_dr got=%h exp=F", domain_rst);
    end
    checks++;
    if (all_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_loss_ready got=%b exp=0", all_ready);
    end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL run_loss_cnt got=%0d exp=1", lock_loss_cnt);
    end
    checks++;
    if (last_loss_mask !== 4'h2) begin
      failures++;
      $display("FAIL run_loss_mask got=%h exp=2", last_loss_mask);
    end
`endif
    pll_locked = 4'hF;
    for (int k = 0; k <= 26; k++) begin
      step();
      checks++;
      if (domain_rst !== exp_dr(k) || all_ready !== (k >= 26)) begin
        failures++;
        $display("FAIL relock_pattern edge=%0d got=%h/%b exp=%h/%b",
                 k, domain_rst, all_ready, exp_dr(k), (k >= 26));
      end
    end
    checks++;
    if (retry_count !== 4'd0) begin
      failures++;
      $display("FAIL run_loss_retry got=%0d exp=0", retry_count);
    end
  endtask

  task automatic test_timeout_retry();
    logic       e_stdy;
    logic [3:0] e_retry;
    logic       e_err;
    do_reset();
    for (int e = 1; e <= 140; e++) begin
      step();
      e_stdy  = (e == 32 || e == 33 || e == 66 || e == 67 || e == 100 || e == 101);
      e_retry = (e < 32) ? 4'd0 : (e < 66) ? 4'd1 : (e < 100) ? 4'd2 : 4'd3;
      e_err   = (e >= 134);
      checks++;
      if (pll_stdy_rst !== e_stdy) begin
        failures++;
        $display("FAIL timeout_stdy edge=%0d got=%b exp=%b", e, pll_stdy_rst, e_stdy);
      end
      checks++;
      if (retry_count !== e_retry) begin
        failures++;
        $display("FAIL timeout_retry edge=%0d got=%0d exp=%0d", e, retry_count, e_retry);
      end
      checks++;
      if (timeout_err !== e_err) begin
        failures++;
        $display("FAIL timeout_err edge=%0d got=%b exp=%b", e, timeout_err, e_err);
      end
      checks++;
      if (domain_rst !== 4'hF) begin
        failures++;
        $display("FAIL timeout_dr edge=%0d got=%h exp=F", e, domain_rst);
      end
    end
    // FAULT is terminal: lock arriving now must not release anything.
    pll_locked = 4'hF;
    for (int k = 0; k < 30; k++) step();
    checks++;
    if (domain_rst !== 4'hF || timeout_err !== 1'b1 || all_ready !== 1'b0) begin
      failures++;
      $display("FAIL fault_terminal got=%h/%b/%b exp=F/1/0", domain_rst, timeout_err, all_ready);
    end
  endtask

  task automatic test_recovery();
    do_reset();
    for (int e = 1; e <= 34; e++) step();
    pll_locked = 4'hF;
    for (int k = 0; k <= 27; k++) begin
      step();
      checks++;
      if (domain_rst !== exp_dr(k)) begin
        failures++;
        $display("FAIL recovery_dr edge=%0d got=%h exp=%h", k, domain_rst, exp_dr(k));
      end
    end
    checks++;
    if (retry_count !== 4'd1) begin
      failures++;
      $display("FAIL recovery_retry got=%0d exp=1", retry_count);
    end
    checks++;
    if (timeout_err !== 1'b0 || all_ready !== 1'b1 || pll_stdy_rst !== 1'b0) begin
      failures++;
      $display("FAIL recovery_flags got=%b/%b/%b exp=0/1/0", timeout_err, all_ready, pll_stdy_rst);
    end
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    for (int e = 1; e <= 34; e++) step();
    pll_locked = 4'hF;
    for (int k = 0; k <= 19; k++) step();
    checks++;
    if (domain_rst !== 4'hC || retry_count !== 4'd1) begin
      failures++;
      $display("FAIL midrel_before got=%h/%0d exp=C/1", domain_rst, retry_count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (domain_rst !== 4'hF) begin
      failures++;
      $display("FAIL midrel_dr got=%h exp=F", domain_rst);
    end
    checks++;
    if (all_ready !== 1'b0 || pll_stdy_rst !== 1'b0) begin
      failures++;
      $display("FAIL midrel_flags got=%b/%b exp=0/0", all_ready, pll_stdy_rst);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      failures++;
      $display("FAIL midrel_retry got=%0d exp=0", retry_count);
    end
    rst = 1'b0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    checks++;
    if (lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midrel_cnt_clear got=%0d exp=0", lock_loss_cnt);
    end
    for (int k = 0; k <= 26; k++) step();
    pll_locked = 4'h0;
    for (int k = 0; k < 3; k++) step();
    checks++;
    if (lock_loss_cnt !== 8'd1 || last_loss_mask !== 4'hF) begin
      failures++;
      $display("FAIL midrel_cnt_loss got=%0d/%h exp=1/F", lock_loss_cnt, last_loss_mask);
    end
`else
    // Sequencing after the mid-release reset restarts from edge 0.
    for (int k = 0; k <= 14; k++) step();
    checks++;
    if (domain_rst !== exp_dr(14)) begin
      failures++;
      $display("FAIL midrel_restart got=%h exp=%h", domain_rst, exp_dr(14));
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 4'h0;
    test_reset();
    test_clean_bringup();
    test_glitch_hold();
    test_run_loss();
    test_timeout_retry();
    test_recovery();
    test_reset_mid_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
